vector_pe: RTL and testbench

- Parametrised successor to serial_pe: LANES multiply-accumulate lanes per beat instead of one.
- Consumes packed neuron/weight vectors with the same ctl/vld_i framing as serial_pe. Multiplies lane-wise, reduces through an adder tree, and accumulates over a group of beats.
- Emits one result per group with a single-cycle vld_o.
- Sits between the neuron/weight line buffers and the result writeback in the DLP datapath.

---
 rtl/vector_pe_pkg.sv | 41 ++++
 rtl/vector_pe_adder_tree.sv | 41 ++++
 rtl/vector_pe.sv | 176 +++++++++++++++++
 tb/tb_vector_pe.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pe_pkg.sv
// vector_pe_pkg: shared types and helpers for the vector processing element.
//   state_e  : accumulate-stage FSM encoding (IDLE, ACC).
//   PROD_W / SUM_W : product and adder-tree widths for the default
//                    configuration (DATA_W=16, LANES=4). Each module derives
//                    its own widths from its parameters using the same rule.
//   sat_acc  : clamps a signed value to the signed range of acc_w bits.
package vector_pe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    localparam int DEF_LANES  = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 32;

    localparam int PROD_W = 2 * DEF_DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(DEF_LANES);

    // The helper works on a fixed 64-bit carrier. The accumulator adder width
    // must therefore stay at or below 64 bits and acc_w below 64.
    localparam int SAT_W = 64;

    function automatic logic signed [SAT_W-1:0] sat_acc(
        input logic signed [SAT_W-1:0] v,
        input int                      acc_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (acc_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/vector_pe_adder_tree.sv
// vector_pe_adder_tree: registered signed reduction of LANES products.
//   clk, rst_n : clock and asynchronous active-low reset.
//   prods      : LANES packed signed products, lane i at [i*PROD_W +: PROD_W].
//   sum        : registered signed sum, PROD_W + log2(LANES) bits, so it
//                can never overflow.
// The tree is built as log2(LANES) levels of pairwise adders; every node is
// already at full output width, so the sign extension happens once at the
// leaves.
module vector_pe_adder_tree #(
    parameter int LANES  = 4,
    parameter int PROD_W = 32
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [LANES*PROD_W-1:0]                  prods,
    output logic signed [PROD_W+$clog2(LANES)-1:0]   sum
);

    localparam int SUM_W = PROD_W + $clog2(LANES);
    localparam int LV    = $clog2(LANES);

    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        logic signed [SUM_W-1:0] n [LANES >> l];
        for (genvar i = 0; i < (LANES >> l); i++) begin : g_node
            if (l == 0) begin : g_leaf
                assign n[i] = SUM_W'($signed(prods[i*PROD_W +: PROD_W]));
            end else begin : g_add
                assign n[i] = g_lvl[l-1].n[2*i] + g_lvl[l-1].n[2*i+1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else begin
            sum <= g_lvl[LV].n[0];
        end
    end

endmodule

// File: rtl/vector_pe.sv
// vector_pe: LANES-wide multiply-accumulate processing element.
//   clk, rst_n     : clock, asynchronous active-low reset.
//   neuron, weight : packed signed vectors, lane i at [i*DATA_W +: DATA_W].
//   ctl            : [0] first beat of group, [1] last beat of group.
//   vld_i          : beat valid.
//   clr_err        : synchronous clear of err_o (a same-cycle set wins).
//   result         : signed group result, held until the next vld_o.
//   vld_o          : one-cycle pulse marking a new result.
//   err_o          : sticky framing-error flag.
// Build option: define VECTOR_PE_SAT_EN to saturate every accumulate step to
// the signed ACC_W range; otherwise the accumulator wraps modulo 2^ACC_W.
//
// Handshake: vld_i qualifies neuron/weight/ctl in the cycle it is high; there
// is no backpressure, so every valid beat is consumed on the edge it is
// sampled. vld_o is a single-cycle pulse with no ready; the consumer must take
// result in that cycle (it also stays stable until the next pulse).
//
// Pipeline, beat sampled at edge k:
//   k   : lane products   (prod_q, v1_q, c1_q)
//   k+1 : adder-tree sum  (sum_q,  v2_q, c2_q)
//   k+2 : accumulator/FSM (acc_q, state_q, emit_q, err_o)
//   k+3 : result, vld_o
module vector_pe
    import vector_pe_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES*DATA_W-1:0]   neuron,
    input  logic [LANES*DATA_W-1:0]   weight,
    input  logic [1:0]                ctl,
    input  logic                      vld_i,
    input  logic                      clr_err,
    output logic signed [ACC_W-1:0]   result,
    output logic                      vld_o,
    output logic                      err_o
);

    localparam int PW = 2 * DATA_W;
    localparam int SW = PW + $clog2(LANES);
    // One guard bit above the wider operand keeps the add exact before
    // wrapping or saturating.
    localparam int AW = ((ACC_W > SW) ? ACC_W : SW) + 1;

    // ---------------- stage 1: lane products ----------------
    logic [LANES*PW-1:0] prod_q;
    logic                v1_q;
    logic [1:0]          c1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
            c1_q   <= 2'b00;
        end else begin
            v1_q <= vld_i;
            // ctl means nothing on a bubble, so it is not carried along.
            c1_q <= vld_i ? ctl : 2'b00;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i*PW +: PW] <= PW'($signed(neuron[i*DATA_W +: DATA_W]))
                                    * PW'($signed(weight[i*DATA_W +: DATA_W]));
            end
        end
    end

    // ---------------- stage 2: adder tree ----------------
    logic signed [SW-1:0] sum_q;
    logic                 v2_q;
    logic [1:0]           c2_q;

    vector_pe_adder_tree #(
        .LANES  (LANES),
        .PROD_W (PW)
    ) u_tree (
        .clk   (clk),
        .rst_n (rst_n),
        .prods (prod_q),
        .sum   (sum_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            c2_q <= 2'b00;
        end else begin
            v2_q <= v1_q;
            c2_q <= c1_q;
        end
    end

    // ---------------- stage 3: accumulate FSM ----------------
    state_e                state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                  emit_q, emit_d;
    logic                  err_set;
    logic                  start;
    logic signed [AW-1:0]  nxt;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        emit_d  = 1'b0;
        err_set = 1'b0;
        start   = 1'b0;
        nxt     = '0;
        if (v2_q) begin
            // A missing first-beat marker in IDLE is an implicit start; a
            // first-beat marker inside a group abandons the old group.
            start   = (state_q == IDLE) || c2_q[0];
            err_set = (state_q == IDLE) ? !c2_q[0] : c2_q[0];
            if (start) begin
                nxt = AW'(sum_q);
            end else begin
                nxt = AW'(acc_q) + AW'(sum_q);
            end
            acc_d = step(nxt);
            if (c2_q[1]) begin
                emit_d  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = ACC;
            end
        end
    end

`ifdef VECTOR_PE_SAT_EN
    function automatic logic signed [ACC_W-1:0] step(input logic signed [AW-1:0] v);
        logic signed [SAT_W-1:0] s;
        logic                    unused_hi;
        s         = sat_acc(SAT_W'(v), ACC_W);
        unused_hi = ^s[SAT_W-1:ACC_W];
        return s[ACC_W-1:0];
    endfunction
`else
    function automatic logic signed [ACC_W-1:0] step(input logic signed [AW-1:0] v);
        logic unused_hi;
        unused_hi = ^v[AW-1:ACC_W];
        return v[ACC_W-1:0];
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            emit_q  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            emit_q  <= emit_d;
            if (err_set) begin
                err_o <= 1'b1;
            end else if (clr_err) begin
                err_o <= 1'b0;
            end
        end
    end

    // ---------------- stage 4: output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            vld_o  <= 1'b0;
        end else begin
            vld_o <= emit_q;
            if (emit_q) begin
                result <= acc_q;
            end
        end
    end

endmodule

// File: tb/tb_vector_pe.sv
// tb_vector_pe: self-checking bench for vector_pe (LANES=4, DATA_W=16,
// ACC_W=32). A behavioural model computes each group's dot-product sum from
// the framing rules and predicts when vld_o pulses, what result holds and
// when err_o changes; one compare process checks every cycle.
module tb_vector_pe;

    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;

    logic                     clk;
    logic                     rst_n;
    logic [LANES*DATA_W-1:0]  neuron;
    logic [LANES*DATA_W-1:0]  weight;
    logic [1:0]               ctl;
    logic                     vld_i;
    logic                     clr_err;
    logic signed [ACC_W-1:0]  result;
    logic                     vld_o;
    logic                     err_o;

    vector_pe #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .neuron  (neuron),
        .weight  (weight),
        .ctl     (ctl),
        .vld_i   (vld_i),
        .clr_err (clr_err),
        .result  (result),
        .vld_o   (vld_o),
        .err_o   (err_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          tests = 0;
    int          fails = 0;
    logic [ACC_W-1:0] exp_q[$];
    int          exp_cyc_q[$];
    bit          set_at[int];
    bit          clr_at[int];
    longint      m_acc = 0;
    bit          m_in_group = 1'b0;
    int          drv_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reduce one accumulate step to the ACC_W result range.
    function automatic longint acc_step(input longint a);
`ifdef VECTOR_PE_SAT_EN
        if (a > 64'sd2147483647)       return 64'sd2147483647;
        else if (a < -64'sd2147483648) return -64'sd2147483648;
        return a;
`else
        return longint'($signed(a[31:0]));
`endif
    endfunction

    function automatic longint dot(input logic [63:0] n, input logic [63:0] w);
        longint s;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            s += longint'($signed(n[i*DATA_W +: DATA_W])) * longint'($signed(w[i*DATA_W +: DATA_W]));
        end
        return s;
    endfunction

    // Beat driven while cyc==n is sampled at edge n+1; the framing error shows
    // after edge n+3 and the result pulse after edge n+4.
    task automatic model_beat(input logic [63:0] n, input logic [63:0] w,
                              input logic [1:0] c, input logic v, input logic clr);
        longint d;
        clr_at[cyc + 1] = clr;
        if (v) begin
            d = dot(n, w);
            if (!m_in_group) begin
                if (!c[0]) set_at[cyc + 3] = 1'b1;
                m_acc = d;
            end else if (c[0]) begin
                set_at[cyc + 3] = 1'b1;
                m_acc = d;
            end else begin
                m_acc = m_acc + d;
            end
            m_acc = acc_step(m_acc);
            if (c[1]) begin
                exp_q.push_back(m_acc[31:0]);
                exp_cyc_q.push_back(cyc + 4);
                m_in_group = 1'b0;
            end else begin
                m_in_group = 1'b1;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic beat(input logic [63:0] n, input logic [63:0] w,
                        input logic [1:0] c, input logic v, input logic clr);
        @(posedge clk);
        #1;
        neuron  = n;
        weight  = w;
        ctl     = c;
        vld_i   = v;
        clr_err = clr;
        drv_cyc = cyc;
        model_beat(n, w, c, v, clr);
    endtask

    task automatic idle();
        beat(64'd0, 64'd0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        vld_i   = 1'b0;
        clr_err = 1'b0;
        ctl     = 2'b00;
        exp_q.delete();
        exp_cyc_q.delete();
        set_at.delete();
        clr_at.delete();
        m_acc      = 0;
        m_in_group = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
        return {d, c, b, a};
    endfunction

    // Wait (bounded) for the next vld_o pulse and pin its result to a literal.
    task automatic expect_lit(input string name, input logic [31:0] val, output int at);
        bit found;
        found = 1'b0;
        at    = -1;
        for (int k = 0; k < 16 && !found; k++) begin
            @(negedge clk);
            if (vld_o === 1'b1) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL %s: got no vld_o within 16 cycles, required a pulse", name);
        end else begin
            chk(name, result, val);
        end
    endtask

    // ---------------- compare process ----------------
    logic        exp_err = 1'b0;
    logic [31:0] exp_res = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_err = 1'b0;
            exp_res = '0;
            chk("rst_result", result, 32'd0);
            chk("rst_vld_o", {31'd0, vld_o}, 32'd0);
            chk("rst_err_o", {31'd0, err_o}, 32'd0);
        end else begin
            if (set_at.exists(cyc)) exp_err = 1'b1;
            else if (clr_at.exists(cyc) && clr_at[cyc]) exp_err = 1'b0;
            chk("err_o", {31'd0, err_o}, {31'd0, exp_err});
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                void'(exp_cyc_q.pop_front());
                exp_res = exp_q.pop_front();
                chk("vld_o", {31'd0, vld_o}, 32'd1);
            end else begin
                chk("vld_o", {31'd0, vld_o}, 32'd0);
            end
            chk("result", result, exp_res);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int at, at2, first;
        logic [63:0] ones, n, w;
        logic [1:0]  c;
        int gen_left;

        rst_n   = 1'b0;
        neuron  = '0;
        weight  = '0;
        ctl     = 2'b00;
        vld_i   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        ones = pack4(16'd1, 16'd1, 16'd1, 16'd1);

        // single-beat group, latency and literal 10
        beat(ones, pack4(16'd1, 16'd2, 16'd3, 16'd4), 2'b11, 1'b1, 1'b0);
        idle();
        expect_lit("one_beat", 32'h0000000A, at);
        chk("one_beat_latency", at - (drv_cyc - 1), 32'd4);
        chk("one_beat_err", {31'd0, err_o}, 32'd0);

        // three-beat group
        n = pack4(16'd2, 16'd2, 16'd2, 16'd2);
        w = pack4(16'd3, 16'd3, 16'd3, 16'd3);
        beat(n, w, 2'b01, 1'b1, 1'b0);
        beat(n, w, 2'b00, 1'b1, 1'b0);
        beat(n, w, 2'b10, 1'b1, 1'b0);
        idle();
        expect_lit("three_beat", 32'h00000048, at);

        // same group with bubbles: pulse slips by the bubble count
        beat(n, w, 2'b01, 1'b1, 1'b0);
        first = drv_cyc;
        beat(n, w, 2'b11, 1'b0, 1'b0);
        beat(n, w, 2'b00, 1'b1, 1'b0);
        beat(n, w, 2'b11, 1'b0, 1'b0);
        beat(n, w, 2'b11, 1'b0, 1'b0);
        beat(n, w, 2'b10, 1'b1, 1'b0);
        idle();
        expect_lit("bubbles", 32'h00000048, at);
        chk("bubbles_latency", at - first, 32'd9);

        // negative products
        beat(pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
             pack4(16'd5, 16'd5, 16'd5, 16'd5), 2'b11, 1'b1, 1'b0);
        idle();
        expect_lit("negative", 32'hFFFFFFEC, at);

        // back-to-back groups
        beat(ones, pack4(16'd1, 16'd2, 16'd3, 16'd4), 2'b11, 1'b1, 1'b0);
        beat(ones, pack4(16'd1, 16'd1, 16'd2, 16'd3), 2'b11, 1'b1, 1'b0);
        idle();
        expect_lit("b2b_first", 32'd10, at);
        expect_lit("b2b_second", 32'd7, at2);
        chk("b2b_gap", at2 - at, 32'd1);

        // largest positive products
        n = pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        beat(n, n, 2'b11, 1'b1, 1'b0);
        idle();
`ifdef VECTOR_PE_SAT_EN
        expect_lit("max_sat", 32'h7FFFFFFF, at);
`else
        expect_lit("max_wrap", 32'hFFFC0004, at);
`endif

        // missing first marker in IDLE: error, group still completes
        beat(ones, pack4(16'd1, 16'd2, 16'd3, 16'd4), 2'b10, 1'b1, 1'b0);
        idle();
        expect_lit("implicit_start", 32'd10, at);
        chk("err_set", {31'd0, err_o}, 32'd1);
        beat(64'd0, 64'd0, 2'b00, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("err_clr", {31'd0, err_o}, 32'd0);

        // reset mid-group discards the partial group
        n = pack4(16'h1234, 16'h0F0F, 16'h7FFF, 16'h8000);
        beat(n, n, 2'b01, 1'b1, 1'b0);
        beat(n, n, 2'b00, 1'b1, 1'b0);
        do_reset();
        beat(ones, pack4(16'd1, 16'd2, 16'd3, 16'd4), 2'b11, 1'b1, 1'b0);
        idle();
        expect_lit("after_reset", 32'd10, at);

        // randomized traffic against the model
        gen_left = 0;
        for (int t = 0; t < 600; t++) begin
            for (int l = 0; l < LANES; l++) begin
                case ($urandom_range(0, 3))
                    0:       n[l*DATA_W +: DATA_W] = 16'h7FFF;
                    1:       n[l*DATA_W +: DATA_W] = 16'h8000;
                    default: n[l*DATA_W +: DATA_W] = 16'($urandom);
                endcase
                case ($urandom_range(0, 3))
                    0:       w[l*DATA_W +: DATA_W] = 16'h7FFF;
                    1:       w[l*DATA_W +: DATA_W] = 16'h8000;
                    default: w[l*DATA_W +: DATA_W] = 16'($urandom);
                endcase
            end
            if ($urandom_range(0, 9) == 0) begin
                c = 2'($urandom_range(0, 3));
            end else begin
                c[0] = (gen_left == 0);
                if (gen_left == 0) gen_left = $urandom_range(1, 6);
                gen_left--;
                c[1] = (gen_left == 0);
            end
            beat(n, w, c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end

        // drain outstanding pulses
        idle();
        for (int k = 0; k < 20 && exp_cyc_q.size() > 0; k++) @(negedge clk);
        chk("drain", exp_cyc_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
